// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the bcd2bin core: controller state encoding,
// default geometry and the nibble correction constant.
package bcd2bin_pkg;

  // Default geometry: 5 BCD digits converted into a 16-bit binary result.
  localparam int unsigned N_DIGITS_DEF = 5;
  localparam int unsigned N_BITS_DEF   = 16;

  // Amount subtracted from each digit >= 8 between right shifts.
  localparam logic [3:0] ADJ_SUB = 4'd3;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_ADJ   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // True when a 4-bit field does not hold a decimal digit.
  function automatic logic nibble_invalid(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/bcd2bin_ctrl_if.sv
// Handshake and control bundle between the bcd2bin controller and its
// requester / datapath. The controller uses the slave view.
interface bcd2bin_ctrl_if
  import bcd2bin_pkg::*;
#(
  parameter int unsigned N_DIGITS = N_DIGITS_DEF
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;

  logic                start;
  logic [BCD_W-1:0]    bcd_in;
  logic [N_DIGITS-1:0] ge8;
  logic                rst_ld;
  logic                shift;
  logic [N_DIGITS-1:0] lda2;
  logic                busy;
  logic                done;
  logic                err;

  // Requester / datapath side.
  modport master (
    output start, bcd_in, ge8,
    input  rst_ld, shift, lda2, busy, done, err
  );

  // Controller side.
  modport slave (
    input  start, bcd_in, ge8,
    output rst_ld, shift, lda2, busy, done, err
  );

endinterface

// File: rtl/bcd_digit_chk.sv
// Combinational invalid-BCD detector: flags any nibble above 9.
// Only compiled when BCD2BIN_CTRL_CHK_EN is defined.
`ifdef BCD2BIN_CTRL_CHK_EN
module bcd_digit_chk
  import bcd2bin_pkg::*;
#(
  parameter int unsigned N_DIGITS = N_DIGITS_DEF
) (
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic                  bad_c
);

  // OR-reduce the per-nibble range checks.
  always_comb begin
    bad_c = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      bad_c = bad_c | nibble_invalid(bcd[4*i +: 4]);
    end
  end

endmodule
`endif

// File: rtl/bcd2bin_ctrl.sv
// Sequencing controller for the bcd2bin shift-and-subtract datapath.
// Runs on the rising edge; the datapath samples the controls on the falling
// edge. Optional invalid-operand check: define BCD2BIN_CTRL_CHK_EN.
module bcd2bin_ctrl
  import bcd2bin_pkg::*;
#(
  parameter int unsigned N_DIGITS = N_DIGITS_DEF,
  parameter int unsigned N_BITS   = N_BITS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bcd2bin_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_ld_q, rst_ld_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             bad_c;

`ifdef BCD2BIN_CTRL_CHK_EN
  bcd_digit_chk #(
    .N_DIGITS (N_DIGITS)
  ) u_digit_chk (
    .bcd   (bus.bcd_in),
    .bad_c (bad_c)
  );
`else
  logic unused_bcd;
  assign unused_bcd = ^bus.bcd_in;
  assign bad_c      = 1'b0;
`endif

  // Next state, step counter and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bad_c) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_ADJ;
        end
      end
      S_ADJ: begin
        state_d = S_SHIFT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rst_ld_d = (state_d == S_LOAD);
    shift_d  = (state_d == S_SHIFT);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State, counter and output registers; reset wins over any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rst_ld_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rst_ld_q <= rst_ld_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.rst_ld = rst_ld_q;
  assign bus.shift  = shift_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

  // ge8 settles inside the ADJ cycle, so it is passed through, gated by state.
  assign bus.lda2 = (state_q == S_ADJ) ? bus.ge8 : '0;

endmodule

// File: tb/tb_bcd2bin_ctrl.sv
// Self-checking bench for bcd2bin_ctrl with a falling-edge datapath model.
module tb_bcd2bin_ctrl;
  import bcd2bin_pkg::*;

  localparam int unsigned ND    = 5;
  localparam int unsigned NB    = 16;
  localparam int unsigned LAST  = 2 * NB + 1;
  localparam int unsigned DP_W  = 4 * ND + NB;
`ifdef BCD2BIN_CTRL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  bcd2bin_ctrl_if #(.N_DIGITS(ND)) bus ();

  bcd2bin_ctrl #(
    .N_DIGITS (ND),
    .N_BITS   (NB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: upper BCD field above a binary field, clocked on negedge.
  logic [DP_W-1:0] dp_q = '0;
  logic [DP_W-1:0] dp_adj;
  logic [ND-1:0]   dp_ge8;
  logic [ND-1:0]   ge8_force;
  logic            dp_mode;

  always_comb begin
    dp_adj = dp_q;
    for (int i = 0; i < ND; i++) begin
      dp_ge8[i] = dp_q[NB + 4*i + 3];
      if (bus.lda2[i]) dp_adj[NB + 4*i +: 4] = dp_q[NB + 4*i +: 4] - ADJ_SUB;
    end
  end

  always @(negedge clk) begin
    if (bus.rst_ld)     dp_q <= {bus.bcd_in, NB'(0)};
    else if (bus.shift) dp_q <= dp_q >> 1;
    else                dp_q <= dp_adj;
  end

  assign bus.ge8 = dp_mode ? dp_ge8 : ge8_force;

  // Reference model: cycles elapsed since the accepted start (0 = idle).
  int unsigned ph = 0;
  bit          em = 1'b0;
  logic [31:0] exp_bin = '0;

  function automatic int unsigned bcd_value(input logic [4*ND-1:0] b);
    int unsigned v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 10 + 32'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [4*ND-1:0] b);
    bit r = 1'b0;
    for (int i = 0; i < ND; i++) if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      ph = 0;
      em = 1'b0;
    end else if (ph == 0) begin
      if (bus.start) begin
        if (CHK && bcd_bad(bus.bcd_in)) begin
          em = 1'b1;
          ph = LAST;
        end else begin
          em      = 1'b0;
          ph      = 1;
          exp_bin = bcd_value(bus.bcd_in) % 32'd65536;
        end
      end
    end else if (ph == LAST) begin
      ph = 0;
      em = 1'b0;
    end else begin
      ph = ph + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h ph=%0d t=%0t", tag, got, exp, ph, $time);
    end
  endtask

  task automatic check_outputs();
    bit is_shift, is_adj;
    is_shift = (ph >= 2) && (ph <= 2 * NB) && (ph % 2 == 0);
    is_adj   = (ph >= 3) && (ph <= 2 * NB - 1) && (ph % 2 == 1);
    chk("rst_ld", 32'(bus.rst_ld), 32'(ph == 1));
    chk("shift",  32'(bus.shift),  32'(is_shift));
    chk("lda2",   32'(bus.lda2),   is_adj ? 32'(bus.ge8) : 32'd0);
    chk("busy",   32'(bus.busy),   32'(ph != 0));
    chk("done",   32'(bus.done),   32'(ph == LAST));
    chk("err",    32'(bus.err),    32'(em && ph == LAST));
    if (dp_mode && ph == LAST && !em) chk("bin", 32'(dp_q[NB-1:0]), exp_bin);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic conv(input logic [4*ND-1:0] b);
    bus.bcd_in = b;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    run(LAST + 2);
  endtask

  function automatic logic [4*ND-1:0] rand_bcd();
    logic [4*ND-1:0] b;
    for (int i = 0; i < ND; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  initial begin
    n_chk      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    ge8_force  = '0;
    dp_mode    = 1'b0;
    run(2);
    rst = 1'b0;
    run(2);

    // Fixed ge8 pattern, then all-zero ge8.
    ge8_force = 5'b10101;
    conv(20'h12345);
    ge8_force = '0;
    conv(20'h12345);

    // End-to-end conversions through the datapath model.
    dp_mode = 1'b1;
    conv(20'h00255);
    conv(20'h65535);
    conv(20'h00000);
    conv(20'h99999);
    for (int k = 0; k < 4; k++) conv(rand_bcd());

    // start re-asserted mid-conversion is ignored.
    bus.bcd_in = 20'h04321;
    bus.start  = 1'b1;
    tick();
    for (int c = 1; c <= LAST + 3; c++) begin
      bus.start = (c == 5 || c == 20);
      tick();
    end
    bus.start = 1'b0;

    // start held high: back-to-back conversions.
    bus.bcd_in = 20'h31415;
    bus.start  = 1'b1;
    run(3 * (LAST + 1) + 4);
    bus.start = 1'b0;
    run(LAST + 2);

    // Reset in the middle of a conversion, then a clean conversion.
    bus.bcd_in = 20'h27182;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    run(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(3);
    conv(20'h27182);

    // Operand with a non-decimal nibble, then the largest valid operand.
    dp_mode = 1'b0;
    conv(20'h0A123);
    dp_mode = 1'b1;
    conv(20'h99999);

    // Random traffic with random ge8, occasional reset and bad operands.
    dp_mode = 1'b0;
    for (int k = 0; k < 600; k++) begin
      bus.start  = ($urandom_range(0, 5) == 0);
      rst        = ($urandom_range(0, 79) == 0);
      bus.bcd_in = ($urandom_range(0, 3) == 0) ? 20'($urandom) : rand_bcd();
      ge8_force  = 5'($urandom);
      tick();
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    run(LAST + 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
